// File: rtl/lcd_mode_sequencer.sv
// LCD mode sequencer: dot/line timing, PPU mode FSM and STAT/VBlank interrupt generation.
// Optional macro LY153_EARLY_ZERO_EN: on line 153 the visible ly drops to 0 from dot 4 onward.
module lcd_mode_sequencer (
    input  logic       clk2,
    input  logic       reset_video,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_ie,
    input  logic       draw_done,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       ly_eq_lyc,
    output logic       int_stat,
    output logic       int_vblank,
    output logic       line_start
);

    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        DRAW   = 2'd3
    } mode_t;

    mode_t      state;
    mode_t      state_next;
    logic       running;
    logic       running_next;
    logic [7:0] line;
    logic [7:0] line_next;
    logic [8:0] dot_next;
    logic [7:0] ly_next;
    logic       ly_eq_next;
    logic       int_stat_next;
    logic       int_vblank_next;
    logic       line_start_next;

    assign mode = state;

    // State register; reset clears everything and leaves the sequencer waiting for lcd_en.
    always_ff @(posedge clk2) begin
        if (reset_video) begin
            state      <= HBLANK;
            running    <= 1'b0;
            line       <= 8'd0;
            dot        <= 9'd0;
            ly         <= 8'd0;
            ly_eq_lyc  <= 1'b0;
            int_stat   <= 1'b0;
            int_vblank <= 1'b0;
            line_start <= 1'b0;
        end else begin
            state      <= state_next;
            running    <= running_next;
            line       <= line_next;
            dot        <= dot_next;
            ly         <= ly_next;
            ly_eq_lyc  <= ly_eq_next;
            int_stat   <= int_stat_next;
            int_vblank <= int_vblank_next;
            line_start <= line_start_next;
        end
    end

    // Next-state logic: counters, mode transitions and the registered interrupt sources.
    always_comb begin
        running_next    = running;
        dot_next        = dot;
        line_next       = line;
        state_next      = state;
        int_vblank_next = 1'b0;
        line_start_next = 1'b0;
        ly_next         = line;
        ly_eq_next      = 1'b0;
        int_stat_next   = 1'b0;

        if (!lcd_en) begin
            running_next = 1'b0;
            dot_next     = 9'd0;
            line_next    = 8'd0;
            state_next   = HBLANK;
        end else if (!running) begin
            // First enabled clock: begin a fresh frame in OAM scan.
            running_next    = 1'b1;
            dot_next        = 9'd0;
            line_next       = 8'd0;
            state_next      = OAM;
            line_start_next = 1'b1;
        end else begin
            if (dot == 9'd455) begin
                dot_next        = 9'd0;
                line_next       = (line == 8'd153) ? 8'd0 : line + 8'd1;
                line_start_next = 1'b1;
            end else begin
                dot_next = dot + 9'd1;
            end

            case (state)
                OAM: begin
                    if (dot_next == 9'd80) begin
                        state_next = DRAW;
                    end
                end
                DRAW: begin
                    // Early draw_done is ignored so DRAW always spans at least 172 dots.
                    if ((draw_done && (dot >= 9'd252)) || (dot_next == 9'd369)) begin
                        state_next = HBLANK;
                    end
                end
                HBLANK: begin
                    if (dot_next == 9'd0) begin
                        if (line_next == 8'd144) begin
                            state_next      = VBLANK;
                            int_vblank_next = 1'b1;
                        end else begin
                            state_next = OAM;
                        end
                    end
                end
                VBLANK: begin
                    if ((dot_next == 9'd0) && (line_next == 8'd0)) begin
                        state_next = OAM;
                    end
                end
                default: state_next = HBLANK;
            endcase
        end

`ifdef LY153_EARLY_ZERO_EN
        ly_next = (running_next && (line_next == 8'd153) && (dot_next >= 9'd4)) ? 8'd0 : line_next;
`else
        ly_next = line_next;
`endif

        ly_eq_next = lcd_en && (ly == lyc);

        // The VBlank-entry clock also raises the mode2 source, matching the original hardware.
        int_stat_next = lcd_en &&
                        (((state_next == HBLANK) && stat_ie[0]) ||
                         ((state_next == VBLANK) && stat_ie[1]) ||
                         ((state_next == OAM)    && stat_ie[2]) ||
                         (int_vblank_next        && stat_ie[2]) ||
                         (ly_eq_next             && stat_ie[3]));
    end

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Self-checking bench for lcd_mode_sequencer: table-driven vectors plus reset/frame sequences.
module tb_lcd_mode_sequencer;

`ifdef LY153_EARLY_ZERO_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk2;
    logic       reset_video;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_ie;
    logic       draw_done;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       ly_eq_lyc;
    logic       int_stat;
    logic       int_vblank;
    logic       line_start;

    typedef struct {
        logic       en;
        logic [7:0] lyc;
        logic [3:0] ie;
        logic       dd;
        int         cycles;
        logic [7:0] ly;
        logic [8:0] dot;
        logic [1:0] mode;
        logic       eq;
        logic       stat;
        logic       vb;
        logic       ls;
    } vec_t;

    vec_t vq[$];
    int   vectors;
    int   misses;
    int   cyc;
    int   vb_count;
    int   vb_misplaced;
    int   starts[$];

    lcd_mode_sequencer dut (
        .clk2        (clk2),
        .reset_video (reset_video),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .stat_ie     (stat_ie),
        .draw_done   (draw_done),
        .ly          (ly),
        .dot         (dot),
        .mode        (mode),
        .ly_eq_lyc   (ly_eq_lyc),
        .int_stat    (int_stat),
        .int_vblank  (int_vblank),
        .line_start  (line_start)
    );

    // Dot clock, period 10.
    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    // Observe every cycle: count VBlank pulses and record where each frame begins.
    always @(negedge clk2) begin
        cyc <= cyc + 1;
        if (int_vblank) begin
            vb_count <= vb_count + 1;
            if (!((ly == 8'd144) && (dot == 9'd0))) vb_misplaced <= vb_misplaced + 1;
        end
        if (line_start && (dot == 9'd0) && (ly == 8'd0) && (mode == 2'd2)) starts.push_back(cyc);
    end

    task automatic add(input logic en, input logic [7:0] l, input logic [3:0] ie, input logic dd,
                       input int n, input logic [7:0] ely, input logic [8:0] edot, input logic [1:0] emode,
                       input logic eeq, input logic estat, input logic evb, input logic els);
        vec_t v;
        v = '{en, l, ie, dd, n, ely, edot, emode, eeq, estat, evb, els};
        vq.push_back(v);
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] l, input logic [3:0] ie,
                                 input logic dd, input int n);
        lcd_en    = en;
        lyc       = l;
        stat_ie   = ie;
        draw_done = dd;
        repeat (n) @(posedge clk2);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] ely, input logic [8:0] edot,
                               input logic [1:0] emode, input logic eeq, input logic estat,
                               input logic evb, input logic els);
        vectors++;
        if ({ly, dot, mode, ly_eq_lyc, int_stat, int_vblank, line_start} !==
            {ely, edot, emode, eeq, estat, evb, els}) begin
            misses++;
            $display("[TB] FAIL %s: got ly=%0d dot=%0d mode=%0d eq=%b stat=%b vb=%b ls=%b, expected ly=%0d dot=%0d mode=%0d eq=%b stat=%b vb=%b ls=%b",
                     name, ly, dot, mode, ly_eq_lyc, int_stat, int_vblank, line_start,
                     ely, edot, emode, eeq, estat, evb, els);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            misses++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        vectors      = 0;
        misses       = 0;
        cyc          = 0;
        vb_count     = 0;
        vb_misplaced = 0;
        reset_video  = 1'b1;
        lcd_en       = 1'b1;
        lyc          = 8'd0;
        stat_ie      = 4'b1111;
        draw_done    = 1'b0;

        // Startup, line 0 timing, draw_done window, disable/re-enable, then a full frame.
        add(0, 200, 4'b0000, 0, 2,     0,   0,   0, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 1,     0,   0,   2, 0, 0, 0, 1);
        add(1, 200, 4'b0000, 0, 1,     0,   1,   2, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 79,    0,   80,  3, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 288,   0,   368, 3, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 1,     0,   369, 0, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 86,    0,   455, 0, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 1,     1,   0,   2, 0, 0, 0, 1);
        add(1, 200, 4'b0100, 0, 1,     1,   1,   2, 0, 1, 0, 0);
        add(1, 200, 4'b0100, 0, 79,    1,   80,  3, 0, 0, 0, 0);
        add(1, 200, 4'b0100, 0, 120,   1,   200, 3, 0, 0, 0, 0);
        add(1, 200, 4'b0100, 1, 1,     1,   201, 3, 0, 0, 0, 0);
        add(1, 200, 4'b0100, 0, 59,    1,   260, 3, 0, 0, 0, 0);
        add(1, 200, 4'b0001, 1, 1,     1,   261, 0, 0, 1, 0, 0);
        add(1, 200, 4'b0001, 0, 194,   1,   455, 0, 0, 1, 0, 0);
        add(1, 200, 4'b0001, 0, 1,     2,   0,   2, 0, 0, 0, 1);
        add(1, 200, 4'b0000, 0, 300,   2,   300, 3, 0, 0, 0, 0);
        add(0, 200, 4'b1111, 0, 1,     0,   0,   0, 0, 0, 0, 0);
        add(0, 200, 4'b1111, 0, 3,     0,   0,   0, 0, 0, 0, 0);
        add(1, 200, 4'b0000, 0, 1,     0,   0,   2, 0, 0, 0, 1);
        add(1, 200, 4'b0100, 0, 65663, 143, 455, 0, 0, 0, 0, 0);
        add(1, 200, 4'b0100, 0, 1,     144, 0,   1, 0, 1, 1, 1);
        add(1, 200, 4'b0100, 0, 1,     144, 1,   1, 0, 0, 0, 0);
        add(1, 0,   4'b1000, 0, 4107,  EARLY ? 8'd0 : 8'd153, 4,   1, 0,     0,     0, 0);
        add(1, 0,   4'b1000, 0, 1,     EARLY ? 8'd0 : 8'd153, 5,   1, EARLY, EARLY, 0, 0);
        add(1, 0,   4'b1000, 0, 450,   EARLY ? 8'd0 : 8'd153, 455, 1, EARLY, EARLY, 0, 0);
        add(1, 0,   4'b1000, 0, 1,     0,   0,   2, EARLY, EARLY, 0, 1);
        add(1, 0,   4'b1000, 0, 1,     0,   1,   2, 1,     1,     0, 0);

        // Reset has priority over an asserted lcd_en.
        applyStimulus(1, 0, 4'b1111, 0, 3);
        checkOutput("reset_hold", 0, 0, 0, 0, 0, 0, 0);
        reset_video = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].en, vq[i].lyc, vq[i].ie, vq[i].dd, vq[i].cycles);
            checkOutput($sformatf("vec%0d", i), vq[i].ly, vq[i].dot, vq[i].mode,
                        vq[i].eq, vq[i].stat, vq[i].vb, vq[i].ls);
        end

        // Frame length between the restart and the 153->0 wrap.
        if (starts.size() >= 3) begin
            checkCount("frame_len", starts[2] - starts[1], 70224);
        end else begin
            checkCount("frame_starts", starts.size(), 3);
        end

        // Mid-frame reset with lcd_en held high, then restart.
        reset_video = 1'b1;
        applyStimulus(1, 0, 4'b1111, 0, 1);
        checkOutput("reset_mid", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 4'b1111, 0, 2);
        checkOutput("reset_mid_hold", 0, 0, 0, 0, 0, 0, 0);
        reset_video = 1'b0;
        applyStimulus(1, 0, 4'b0100, 0, 1);
        checkOutput("restart", 0, 0, 2, 1, 1, 0, 1);
        applyStimulus(1, 0, 4'b0100, 0, 1);
        checkOutput("restart_dot1", 0, 1, 2, 1, 1, 0, 0);

        checkCount("vblank_pulses", vb_count, 1);
        checkCount("vblank_placement", vb_misplaced, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
